gsim_host: RTL and testbench

Host-side sequencer that drives the GSIM solver over its stream interface and collects the result. It holds an N-entry right-hand-side buffer written by the host, sends it to the solver as one contiguous `in_en` burst, and waits for the `out_valid` burst. It captures the N solution words into a readable result buffer and reports completion or timeout. It sits between the system register/memory port and the solver core.

---
 rtl/gsim_host.sv | 145 ++++++++++++++
 tb/tb_gsim_host.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_host.sv
// Host-side sequencer for the GSIM solver: buffers the right-hand side, streams it
// out as one burst, captures the solution burst and reports completion or timeout.
module gsim_host #(
   parameter int unsigned N       = 16,
   parameter int unsigned TIMEOUT = 4095,
   parameter int unsigned TW      = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic        start,
   input  logic [3:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        in_en,
   output logic [15:0] b_in,
   input  logic        out_valid,
   input  logic [31:0] x_out
);

   localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned KW = $clog2(N + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SEND  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RECV  = 3'd3;
   localparam logic [2:0] S_FLUSH = 3'd4;

   logic [2:0]    state, state_nx;
   logic [KW-1:0] k, k_nx, j, j_nx;
   logic [TW-1:0] timer, timer_nx;
   logic          in_en_nx, done_nx, err_nx;
   logic [15:0]   b_in_nx;
   logic          wr_ok_c, cap_c;
   logic [AW-1:0] cap_idx_c;

   logic [15:0] b_mem  [N];
   logic [31:0] result [N];

   assign wr_ok_c = (state == S_IDLE) && wr_en && (32'(wr_addr) < N);

   // Next-state and next-output decode
   always_comb begin
      state_nx  = state;
      k_nx      = k;
      j_nx      = j;
      timer_nx  = timer;
      in_en_nx  = in_en;
      b_in_nx   = b_in;
      done_nx   = 1'b0;
      err_nx    = err;
      cap_c     = 1'b0;
      cap_idx_c = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_SEND;
               k_nx     = KW'(1);
               in_en_nx = 1'b1;
               err_nx   = 1'b0;
               // A write landing in the launch cycle must reach word 0
               b_in_nx  = (wr_ok_c && wr_addr == 4'd0) ? wr_data : b_mem[0];
            end
         end
         S_SEND: begin
            if (k == KW'(N)) begin
               state_nx = S_WAIT;
               in_en_nx = 1'b0;
               b_in_nx  = '0;
               timer_nx = '0;
            end else begin
               b_in_nx = b_mem[k[AW-1:0]];
               k_nx    = k + KW'(1);
            end
         end
         S_WAIT: begin
            if (out_valid) begin
               cap_c     = 1'b1;
               cap_idx_c = '0;
               j_nx      = KW'(1);
               state_nx  = (N == 1) ? S_FLUSH : S_RECV;
            end else if (timer >= TW'(TIMEOUT)) begin
               err_nx   = 1'b1;
               done_nx  = 1'b1;
               state_nx = S_IDLE;
            end else begin
               timer_nx = timer + TW'(1);
            end
         end
         S_RECV: begin
            if (out_valid) begin
               cap_c     = 1'b1;
               cap_idx_c = j[AW-1:0];
               j_nx      = j + KW'(1);
               if (j == KW'(N - 1)) state_nx = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (!out_valid) begin
               done_nx  = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         k       <= '0;
         j       <= '0;
         timer   <= '0;
         in_en   <= 1'b0;
         b_in    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         rd_data <= '0;
         for (int i = 0; i < int'(N); i++) begin
            b_mem[i]  <= '0;
            result[i] <= '0;
         end
      end else begin
         state   <= state_nx;
         k       <= k_nx;
         j       <= j_nx;
         timer   <= timer_nx;
         in_en   <= in_en_nx;
         b_in    <= b_in_nx;
         busy    <= (state_nx != S_IDLE);
         done    <= done_nx;
         err     <= err_nx;
         rd_data <= (32'(rd_addr) < N) ? result[rd_addr[AW-1:0]] : '0;
         if (wr_ok_c) b_mem[wr_addr[AW-1:0]] <= wr_data;
         if (cap_c)   result[cap_idx_c] <= x_out;
      end
   end

endmodule

// File: tb/tb_gsim_host.sv
// Scoreboard bench for gsim_host: randomized runs against a queue/array model of the
// host buffers, with a decoupled monitor checking the burst, completion and read port.
module tb_gsim_host;

   localparam int unsigned N       = 16;
   localparam int unsigned TIMEOUT = 4095;
   localparam int unsigned TW      = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        start = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        busy, done, err, in_en;
   logic [15:0] b_in;
   logic        out_valid = 1'b0;
   logic [31:0] x_out = '0;

   logic        rd_req = 1'b0;
   logic        rd_req_d1 = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [15:0] bmod   [N];
   logic [31:0] resmod [N];
   logic [15:0] exp_b    [$];
   logic        exp_done [$];
   logic [31:0] exp_rd   [$];

   gsim_host #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
      .err(err), .in_en(in_en), .b_in(b_in), .out_valid(out_valid), .x_out(x_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rd_req_d1 <= rd_req;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s (t=%0t)", name, what, $time);
   endtask

   // Output monitor: pops the scoreboard whenever the DUT presents something
   task automatic monitor();
      int run_len = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run_len = 0;
         end else begin
            if (in_en) begin
               if (exp_b.size() == 0) fail_now("b_in_unexpected", $sformatf("got %h, no burst expected", b_in));
               else chk("b_in", 32'(b_in), 32'(exp_b.pop_front()));
               run_len++;
            end else begin
               if (run_len != 0) begin
                  chk("burst_len", 32'(run_len), 32'(N));
                  run_len = 0;
               end
               chk("b_in_idle", 32'(b_in), 32'd0);
            end
            if (done) begin
               if (exp_done.size() == 0) fail_now("done_unexpected", "done pulse with no run pending");
               else chk("done_err", 32'(err), 32'(exp_done.pop_front()));
               chk("busy_at_done", 32'(busy), 32'd0);
            end
            if (rd_req_d1) begin
               if (exp_rd.size() == 0) fail_now("rd_unexpected", "read result with no request");
               else chk("rd_data", rd_data, exp_rd.pop_front());
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
      if (32'(a) < N) bmod[a] = d;
   endtask

   task automatic check_results();
      for (int a = 0; a < int'(N); a++) begin
         rd_addr = 4'(a);
         rd_req  = 1'b1;
         exp_rd.push_back(resmod[a]);
         tick();
      end
      rd_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic do_run(input bit to, input int extra, input int gap_at, input int gap_len,
                         input int delay, input bit seq_words, input bit protect, input bit sw);
      int cnt;
      logic [31:0] w;
      if (sw) begin
         wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'($urandom);
         bmod[0] = wr_data;
      end
      for (int i = 0; i < int'(N); i++) exp_b.push_back(bmod[i]);
      start = 1'b1;
      tick();
      start = 1'b0; wr_en = 1'b0;
      cnt = 1;
      chk("busy_on_start", 32'(busy), 32'd1);
      chk("err_clear", 32'(err), 32'd0);
      for (int s = 1; s <= int'(N); s++) begin
         if (protect && s == 3) begin
            wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hFFFF; start = 1'b1;
            out_valid = 1'b1; x_out = 32'hDEAD_BEEF;
         end else begin
            wr_en = 1'b0; start = 1'b0; out_valid = 1'b0; x_out = '0;
         end
         tick();
         cnt++;
      end
      if (protect) begin
         wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hFFFF; start = 1'b1;
         tick();
         cnt++;
         wr_en = 1'b0; start = 1'b0;
      end
      if (to) begin
         exp_done.push_back(1'b1);
         while (!done && cnt < int'(N + TIMEOUT) + 50) begin
            tick();
            cnt++;
         end
         if (!done) fail_now("timeout_wait", "no done within budget");
         else if (!protect) chk("timeout_latency", 32'(cnt), 32'(N + TIMEOUT + 2));
      end else begin
         exp_done.push_back(1'b0);
         repeat (delay) tick();
         for (int i = 0; i < int'(N) + extra; i++) begin
            if (i == gap_at) begin
               out_valid = 1'b0;
               repeat (gap_len) tick();
            end
            w = seq_words ? 32'hA000_0000 + 32'(i) : $urandom;
            out_valid = 1'b1; x_out = w;
            if (i < int'(N)) resmod[i] = w;
            tick();
         end
         out_valid = 1'b0; x_out = '0;
         cnt = 0;
         while (!done && cnt < 100) begin
            tick();
            cnt++;
         end
         if (!done) fail_now("done_wait", "no done after result burst");
      end
   endtask

   initial begin
      for (int i = 0; i < int'(N); i++) begin
         bmod[i] = '0;
         resmod[i] = '0;
      end
      fork
         monitor();
      join_none

      #3;
      chk("rst_in_en", 32'(in_en), 32'd0);
      chk("rst_b_in", 32'(b_in), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Basic run: ramp in, 17-word ramp out
      for (int k = 0; k < int'(N); k++) wr(4'(k), 16'h0100 + 16'(k));
      do_run(1'b0, 1, -1, 0, 2, 1'b1, 1'b0, 1'b0);
      check_results();

      // Gapped result burst
      do_run(1'b0, 0, 8, 3, 0, 1'b0, 1'b0, 1'b0);
      check_results();

      // Protection during SEND/WAIT, then the same write from IDLE
      do_run(1'b0, 1, -1, 0, 4, 1'b0, 1'b1, 1'b0);
      do_run(1'b0, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0);
      wr(4'd3, 16'hFFFF);
      do_run(1'b0, 2, -1, 0, 1, 1'b0, 1'b0, 1'b0);
      check_results();

      // Write and start in the same cycle
      do_run(1'b0, 0, -1, 0, 0, 1'b0, 1'b0, 1'b1);

      for (int r = 0; r < 5; r++) begin
         repeat (6) wr(4'($urandom), 16'($urandom));
         do_run(1'b0, int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N - 1)) : -1,
                int'($urandom_range(1, 4)), int'($urandom_range(0, 10)),
                1'b0, 1'b0, 1'($urandom_range(0, 1)));
         check_results();
      end

      // Timeout leaves results alone; next start clears err
      do_run(1'b1, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0);
      chk("err_sticky", 32'(err), 32'd1);
      check_results();
      do_run(1'b0, 0, -1, 0, 3, 1'b0, 1'b0, 1'b0);
      check_results();

      // Reset in SEND cycle 5
      for (int i = 0; i < int'(N); i++) exp_b.push_back(bmod[i]);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("pre_reset_in_en", 32'(in_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_en", 32'(in_en), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_b_in", 32'(b_in), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      exp_b.delete();
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
         bmod[i] = '0;
         resmod[i] = '0;
      end
      tick();
      check_results();
      do_run(1'b0, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0);
      check_results();

      repeat (3) tick();
      chk("b_queue_left", 32'(exp_b.size()), 32'd0);
      chk("done_queue_left", 32'(exp_done.size()), 32'd0);
      chk("rd_queue_left", 32'(exp_rd.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
